parity_frame_gen: RTL and testbench

Streaming parity generator for the dataflow parity family. It takes DATA_W-bit words over a valid/ready handshake and emits each word with a per-word parity bit appended as the MSB. The parity is even or odd, selectable per frame. After every FRAME_LEN data words it inserts one trailer beat carrying the longitudinal (column) parity of the frame, marked with m_last. It sits between a word source and a serialiser/link that needs both per-word and per-frame parity protection.

---
 rtl/parity_frame_gen_if.sv | 24 ++
 rtl/parity_frame_gen.sv | 140 ++++++++++++++
 tb/tb_parity_frame_gen.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/parity_frame_gen_if.sv
// Valid/ready stream bundle for parity_frame_gen. It carries the input word
// stream and the parity-extended output stream, which includes the trailer beats.
interface parity_frame_gen_if #(
  parameter int DATA_W = 9
);
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W:0]   m_data;
  logic              m_last;

  // The word source and the downstream sink sit on the master side.
  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_data, m_last
  );

  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_data, m_last
  );
endinterface

// File: rtl/parity_frame_gen.sv
// Streaming parity generator. Each word gets a parity MSB, and every FRAME_LEN words
// are followed by one trailer beat that carries the column parity of the frame.
module parity_frame_gen #(
  parameter int DATA_W    = 9,
  parameter int FRAME_LEN = 4,
  parameter int CNT_W     = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               odd_mode,
  parity_frame_gen_if.slave  bus,
  output logic [CNT_W-1:0]   frame_cnt
);

  localparam int              WC_W    = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(FRAME_LEN - 1);

  typedef enum logic [0:0] {
    ST_DATA  = 1'b0,
    ST_TRAIL = 1'b1
  } state_t;

  function automatic logic parity_f(input logic [DATA_W-1:0] w, input logic m);
    return (^w) ^ m;
  endfunction

  state_t              state;
  state_t              state_nxt;
  logic [WC_W-1:0]     word_cnt;
  logic [DATA_W-1:0]   acc;
  logic                mode;

  logic                out_free;
  logic                s_ready_c;
  logic                word_load;
  logic                trail_load;
  logic                first_word;
  logic                cur_mode;
  logic [DATA_W-1:0]   acc_nxt;

  logic                vld_p1;
  logic                last_p1;
  logic [DATA_W:0]     data_p1;

  assign first_word = (word_cnt == '0);
  assign cur_mode   = first_word ? odd_mode : mode;
  assign acc_nxt    = first_word ? bus.s_data : (acc ^ bus.s_data);

  always_comb begin
    state_nxt  = state;
    out_free   = !vld_p1 || bus.m_ready;
    s_ready_c  = 1'b0;
    word_load  = 1'b0;
    trail_load = 1'b0;
    case (state)
      ST_DATA: begin
        s_ready_c = rst_n && out_free;
        word_load = s_ready_c && bus.s_valid;
        if (word_load && (word_cnt == WC_LAST)) begin
          state_nxt = ST_TRAIL;
        end
      end
      ST_TRAIL: begin
        if (out_free) begin
          trail_load = 1'b1;
          state_nxt  = ST_DATA;
        end
      end
      default: state_nxt = ST_DATA;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_DATA;
    end else begin
      state <= state_nxt;
    end
  end

  // The word count saturates at the last index and is cleared when the trailer loads.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      word_cnt <= '0;
      acc      <= '0;
      mode     <= 1'b0;
    end else if (trail_load) begin
      word_cnt <= '0;
      acc      <= '0;
    end else if (word_load) begin
      acc      <= acc_nxt;
      mode     <= cur_mode;
      word_cnt <= (word_cnt == WC_LAST) ? word_cnt : word_cnt + WC_W'(1);
    end
  end

  // Output register stage (p1)
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
      data_p1 <= '0;
    end else if (trail_load) begin
      vld_p1  <= 1'b1;
      last_p1 <= 1'b1;
      data_p1 <= {parity_f(acc, mode), acc};
    end else if (word_load) begin
      vld_p1  <= 1'b1;
      last_p1 <= 1'b0;
      data_p1 <= {parity_f(bus.s_data, cur_mode), bus.s_data};
    end else if (bus.m_ready) begin
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_cnt <= '0;
    end else if (vld_p1 && bus.m_ready && last_p1) begin
      frame_cnt <= frame_cnt + CNT_W'(1);
    end
  end

  assign bus.s_ready = s_ready_c;
  assign bus.m_valid = vld_p1;
  assign bus.m_last  = last_p1;
  assign bus.m_data  = data_p1;

  a_hold_under_backpressure: assert property (
    @(posedge clk) disable iff (!rst_n)
    (vld_p1 && !bus.m_ready) |=> (vld_p1 && $stable(data_p1) && $stable(last_p1))
  );

  a_no_accept_in_trail: assert property (
    @(posedge clk) disable iff (!rst_n)
    (state == ST_TRAIL) |-> !s_ready_c
  );

endmodule

// File: tb/tb_parity_frame_gen.sv
// Directed bench for parity_frame_gen. It checks per-word parity, the trailer, backpressure,
// the mode latch and mid-frame reset. A second instance with CNT_W=2 checks the counter wrap.
module tb_parity_frame_gen;

  localparam int DATA_W    = 9;
  localparam int FRAME_LEN = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic              odd_mode;
  logic              s_valid;
  logic              m_ready;
  logic [DATA_W-1:0] s_data;
  logic [7:0]        frame_cnt;
  logic [1:0]        frame_cnt2;

  int n_checks   = 0;
  int n_pass     = 0;
  int exp_frames = 0;
  int sr_low     = 0;
  logic sr_win   = 1'b0;

  logic [DATA_W:0] got_data[$];
  logic            got_last[$];
  logic [DATA_W:0] exp_data[$];
  logic            exp_last[$];

  parity_frame_gen_if #(.DATA_W(DATA_W)) bus  ();
  parity_frame_gen_if #(.DATA_W(DATA_W)) bus2 ();

  assign bus.s_valid  = s_valid;
  assign bus.s_data   = s_data;
  assign bus.m_ready  = m_ready;
  assign bus2.s_valid = s_valid;
  assign bus2.s_data  = s_data;
  assign bus2.m_ready = m_ready;

  parity_frame_gen #(.DATA_W(DATA_W), .FRAME_LEN(FRAME_LEN), .CNT_W(8)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .odd_mode  (odd_mode),
    .bus       (bus.slave),
    .frame_cnt (frame_cnt)
  );

  parity_frame_gen #(.DATA_W(DATA_W), .FRAME_LEN(FRAME_LEN), .CNT_W(2)) u_dut2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .odd_mode  (odd_mode),
    .bus       (bus2.slave),
    .frame_cnt (frame_cnt2)
  );

  // Record every beat that will transfer on the coming rising edge.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.m_valid === 1'b1 && m_ready === 1'b1) begin
      got_data.push_back(bus.m_data);
      got_last.push_back(bus.m_last);
    end
    if (sr_win && bus.s_ready !== 1'b1) sr_low <= sr_low + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DATA_W-1:0] d);
    int k;
    k = 0;
    s_valid = 1'b1;
    s_data  = d;
    #1;
    while (bus.s_ready !== 1'b1 && k < 100) begin
      @(posedge clk);
      #2;
      k++;
    end
    if (k >= 100) check("send_timeout", k, 0);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  task automatic exp_beat(input logic [DATA_W:0] d, input logic l);
    exp_data.push_back(d);
    exp_last.push_back(l);
  endtask

  task automatic drain(input string tag);
    int k;
    k = 0;
    while (got_data.size() < exp_data.size() && k < 100) begin
      tick();
      k++;
    end
    repeat (3) tick();
    check({tag, "_nbeats"}, got_data.size(), exp_data.size());
    for (int i = 0; i < exp_data.size(); i++) begin
      if (i < got_data.size()) begin
        check($sformatf("%s_data%0d", tag, i), got_data[i], exp_data[i]);
        check($sformatf("%s_last%0d", tag, i), got_last[i], exp_last[i]);
      end
    end
    check({tag, "_frame_cnt"}, frame_cnt, exp_frames % 256);
    check({tag, "_frame_cnt2"}, frame_cnt2, exp_frames % 4);
    got_data.delete();
    got_last.delete();
    exp_data.delete();
    exp_last.delete();
  endtask

  initial begin
    int sr_base;
    rst_n    = 1'b0;
    odd_mode = 1'b0;
    s_valid  = 1'b1;
    s_data   = 9'h1FF;
    m_ready  = 1'b1;

    // Reset held with a valid word presented
    repeat (3) tick();
    #1;
    check("rst_m_valid", bus.m_valid, 0);
    check("rst_s_ready", bus.s_ready, 0);
    check("rst_m_last", bus.m_last, 0);
    check("rst_m_data", bus.m_data, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    check("rst_frame_cnt2", frame_cnt2, 0);
    check("rst_no_beats", got_data.size(), 0);
    s_valid = 1'b0;
    rst_n   = 1'b1;
    tick();

    // Per-word parity, even frame
    send(9'h000); send(9'h155); send(9'h000); send(9'h155);
    exp_beat(10'h000, 0); exp_beat(10'h355, 0); exp_beat(10'h000, 0); exp_beat(10'h355, 0);
    exp_beat(10'h000, 1);
    exp_frames = 1;
    drain("even_words");

    // Per-word parity, odd frame
    odd_mode = 1'b1;
    send(9'h000); send(9'h155); send(9'h000); send(9'h155);
    exp_beat(10'h200, 0); exp_beat(10'h155, 0); exp_beat(10'h200, 0); exp_beat(10'h155, 0);
    exp_beat(10'h200, 1);
    exp_frames = 2;
    drain("odd_words");
    odd_mode = 1'b0;

    // Back-to-back frame with the trailer gap measured
    sr_base = sr_low;
    sr_win  = 1'b1;
    send(9'h001); send(9'h002); send(9'h004); send(9'h008);
    tick(); tick();
    sr_win = 1'b0;
    check("sready_low_cycles", sr_low - sr_base, 1);
    exp_beat(10'h201, 0); exp_beat(10'h202, 0); exp_beat(10'h204, 0); exp_beat(10'h208, 0);
    exp_beat(10'h00F, 1);
    exp_frames = 3;
    drain("frame_1248");

    // Backpressure after word 2
    send(9'h001); send(9'h002);
    m_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("bp_data%0d", i), bus.m_data, 10'h202);
      check($sformatf("bp_valid%0d", i), bus.m_valid, 1);
      check($sformatf("bp_sready%0d", i), bus.s_ready, 0);
      @(posedge clk);
      #1;
    end
    m_ready = 1'b1;
    send(9'h004); send(9'h008);
    exp_beat(10'h201, 0); exp_beat(10'h202, 0); exp_beat(10'h204, 0); exp_beat(10'h208, 0);
    exp_beat(10'h00F, 1);
    exp_frames = 4;
    drain("backpressure");

    // odd_mode rises mid-frame: this frame stays even, the next one is odd
    send(9'h001);
    odd_mode = 1'b1;
    send(9'h002); send(9'h004); send(9'h008);
    exp_beat(10'h201, 0); exp_beat(10'h202, 0); exp_beat(10'h204, 0); exp_beat(10'h208, 0);
    exp_beat(10'h00F, 1);
    exp_frames = 5;
    drain("mode_hold");
    send(9'h003); send(9'h005); send(9'h006); send(9'h007);
    exp_beat(10'h203, 0); exp_beat(10'h205, 0); exp_beat(10'h206, 0); exp_beat(10'h007, 0);
    exp_beat(10'h007, 1);
    exp_frames = 6;
    drain("mode_next");
    odd_mode = 1'b0;

    // Reset after two words, then a fresh frame
    send(9'h0AA); send(9'h055);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    check("midrst_m_valid", bus.m_valid, 0);
    check("midrst_frame_cnt", frame_cnt, 0);
    tick();
    send(9'h001); send(9'h002); send(9'h004); send(9'h008);
    exp_beat(10'h0AA, 0);
    exp_beat(10'h201, 0); exp_beat(10'h202, 0); exp_beat(10'h204, 0); exp_beat(10'h208, 0);
    exp_beat(10'h00F, 1);
    exp_frames = 1;
    drain("after_reset");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
